// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-response receive path.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_48   = 2'b01,
    RESP_136  = 2'b10,
    RESP_48B  = 2'b11
  } resp_type_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         FRAME_48  = 48;
  localparam int         FRAME_136 = 136;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECV,
    S_DONE
  } state_e;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero initial value.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/cmd_resp_checker.sv
// Receives a serial SD command response, extracts its payload and raises
// the timeout / CRC / end-bit / index error flags.
module cmd_resp_checker
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64,
  parameter int CNT_W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   resp_type,
  input  logic         crc_chk_en,
  input  logic         idx_chk_en,
  input  logic [5:0]   exp_index,
  input  logic         bit_en,
  input  logic         cmd_in,
  output logic [119:0] resp_data,
  output logic         resp_done,
  output logic         busy,
  output logic         CommandTimeoutErr,
  output logic         CommandCRCErr,
  output logic         CommandEndBitErr,
  output logic         CommandIndexErr
);

  state_e             state, state_nxt;
  logic               r2;
  logic [CNT_W-1:0]   bcnt, tcnt;
  logic [126:0]       sh;
  logic [127:0]       sh_nxt;
  logic [6:0]         crc;
  logic               start_go, samp_start, tmo, last, in_win;

  assign start_go   = start && (resp_type != RESP_NONE);
  assign samp_start = (state == S_WAIT_START) && bit_en && !cmd_in;
  assign tmo        = (state == S_WAIT_START) && bit_en && cmd_in &&
                      (tcnt == CNT_W'(TIMEOUT_BITS - 1));
  assign last       = (state == S_RECV) && bit_en && (bcnt == CNT_W'(1));
  // sh_nxt[k] is frame bit k once the end bit (k=0) has been shifted in
  assign sh_nxt     = {sh, cmd_in};

  // bcnt-1 is the index of the bit being sampled in RECV; the 48-bit start
  // bit is sampled in WAIT_START and is part of the CRC span
  assign in_win = ((state == S_WAIT_START) && !cmd_in && !r2) ||
                  ((state == S_RECV) && (bcnt >= CNT_W'(9)) &&
                   (bcnt <= (r2 ? CNT_W'(128) : CNT_W'(FRAME_48 - 1))));

  crc7_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (bit_en & in_win),
    .din (cmd_in),
    .crc (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    resp_done = 1'b0;
    busy      = 1'b0;
    if (start) begin
      state_nxt = start_go ? S_WAIT_START : S_IDLE;
    end else begin
      case (state)
        S_IDLE:       if (start_go) state_nxt = S_WAIT_START;
        S_WAIT_START: if (samp_start) state_nxt = S_RECV;
                      else if (tmo) state_nxt = S_DONE;
        S_RECV:       if (last) state_nxt = S_DONE;
        S_DONE:       state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
    case (state)
      S_WAIT_START, S_RECV: busy = 1'b1;
      S_DONE:               resp_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2                <= 1'b0;
      bcnt              <= '0;
      tcnt              <= '0;
      sh                <= '0;
      resp_data         <= '0;
      CommandTimeoutErr <= 1'b0;
      CommandCRCErr     <= 1'b0;
      CommandEndBitErr  <= 1'b0;
      CommandIndexErr   <= 1'b0;
    end else if (start) begin
      r2                <= (resp_type == RESP_136);
      tcnt              <= '0;
      sh                <= '0;
      CommandTimeoutErr <= 1'b0;
      CommandCRCErr     <= 1'b0;
      CommandEndBitErr  <= 1'b0;
      CommandIndexErr   <= 1'b0;
    end else if (bit_en) begin
      case (state)
        S_WAIT_START: begin
          if (!cmd_in) begin
            bcnt <= r2 ? CNT_W'(FRAME_136 - 1) : CNT_W'(FRAME_48 - 1);
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tmo) CommandTimeoutErr <= 1'b1;
          end
        end
        S_RECV: begin
          sh   <= sh_nxt[126:0];
          bcnt <= bcnt - 1'b1;
          // end bit arrives now: everything else is already in sh / crc
          if (last) begin
            resp_data        <= r2 ? sh_nxt[127:8] : {88'd0, sh_nxt[39:8]};
            CommandEndBitErr <= !sh_nxt[0];
            CommandCRCErr    <= crc_chk_en && (sh_nxt[7:1] != crc);
            CommandIndexErr  <= !r2 && idx_chk_en && (sh_nxt[45:40] != exp_index);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_resp_checker.sv
// Directed and randomized frames checked against a polynomial-division
// reference model of the response checker.
module tb_cmd_resp_checker;

  logic         clk = 1'b0;
  logic         rst, start, crc_chk_en, idx_chk_en, bit_en, cmd_in;
  logic [1:0]   resp_type;
  logic [5:0]   exp_index;
  logic [119:0] resp_data;
  logic         resp_done, busy, to_err, crc_err, end_err, idx_err;

  int checks = 0, errors = 0, done_seen = 0;

  cmd_resp_checker #(.TIMEOUT_BITS(64), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .resp_type         (resp_type),
    .crc_chk_en        (crc_chk_en),
    .idx_chk_en        (idx_chk_en),
    .exp_index         (exp_index),
    .bit_en            (bit_en),
    .cmd_in            (cmd_in),
    .resp_data         (resp_data),
    .resp_done         (resp_done),
    .busy              (busy),
    .CommandTimeoutErr (to_err),
    .CommandCRCErr     (crc_err),
    .CommandEndBitErr  (end_err),
    .CommandIndexErr   (idx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resp_done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [135:0] fr, input int hi);
    bit m[$];
    logic [7:0] g = 8'b1000_1001;
    logic [6:0] r;
    int n = hi - 7;
    for (int i = hi; i >= 8; i--) m.push_back(fr[i]);
    repeat (7) m.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (m[i]) for (int k = 0; k < 8; k++) m[i+k] = m[i+k] ^ g[7-k];
    for (int k = 0; k < 7; k++) r[6-k] = m[n+k];
    return r;
  endfunction

  task automatic idle_tick();
    @(negedge clk); bit_en = 1'b0; cmd_in = 1'($urandom);
  endtask

  task automatic do_start(input logic [1:0] t, input logic ce, input logic ie, input logic [5:0] ei);
    @(negedge clk);
    start = 1'b1; resp_type = t; crc_chk_en = ce; idx_chk_en = ie; exp_index = ei;
    bit_en = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gmax);
    repeat ($urandom_range(0, gmax)) idle_tick();
    @(negedge clk); bit_en = 1'b1; cmd_in = b;
  endtask

  // idle ones, then the top nbits of the frame, MSB first
  task automatic send_frame(input logic [135:0] fr, input int len, input int idle,
                            input int nbits, input int gmax);
    repeat (idle) send_bit(1'b1, gmax);
    for (int i = len - 1; i >= len - nbits; i--) send_bit(fr[i], gmax);
    idle_tick();
  endtask

  // called on the cycle after the end bit was sampled
  task automatic check_resp(input string tag, input logic [135:0] fr, input int len,
                            input logic ce, input logic ie, input logic [5:0] ei);
    logic r2 = (len == 136);
    logic [119:0] ed = r2 ? fr[127:8] : {88'd0, fr[39:8]};
    logic ec = ce && (fr[7:1] != crc7_ref(fr, r2 ? 127 : 47));
    logic ex = !r2 && ie && (fr[45:40] != ei);
    check({tag, "_done"}, resp_done, 1);
    check({tag, "_data"}, resp_data, ed);
    check({tag, "_to"},   to_err, 0);
    check({tag, "_crc"},  crc_err, ec);
    check({tag, "_end"},  end_err, !fr[0]);
    check({tag, "_idx"},  idx_err, ex);
    idle_tick();
    check({tag, "_done_pulse"}, resp_done, 0);
    check({tag, "_hold"}, {busy, crc_err, end_err, idx_err}, {1'b0, ec, !fr[0], ex});
  endtask

  logic [135:0] fr;
  int           d0;

  initial begin
    rst = 1'b1; start = 0; resp_type = 0; crc_chk_en = 0; idx_chk_en = 0;
    exp_index = 0; bit_en = 0; cmd_in = 1;
    #12;
    check("reset_out", {resp_data, resp_done, busy, to_err, crc_err, end_err, idx_err}, 0);
    @(negedge clk); rst = 1'b0;

    // bit_en in IDLE is ignored
    repeat (5) send_bit(1'b0, 1);
    idle_tick();
    check("idle_ignore", {busy, done_seen[0]}, 0);

    // 1: good CMD8-style R7
    fr = {88'd0, 48'h48_000001AA_87};
    check("t1_crc_model", crc7_ref(fr, 47), 7'h43);
    do_start(2'b01, 1, 1, 6'd8);
    send_frame(fr, 48, 3, 48, 2);
    check("t1_data32", resp_data[31:0], 32'h0000_01AA);
    check_resp("t1", fr, 48, 1, 1, 6'd8);

    // 2: corrupted CRC field, then with CRC check disabled
    fr = {88'd0, 40'h40_00000000, 7'h4B, 1'b1};
    do_start(2'b01, 1, 0, 6'd0);
    send_frame(fr, 48, 0, 48, 1);
    check("t2_crcerr", crc_err, 1);
    check_resp("t2a", fr, 48, 1, 0, 6'd0);
    do_start(2'b01, 0, 0, 6'd0);
    send_frame(fr, 48, 0, 48, 1);
    check_resp("t2b", fr, 48, 0, 0, 6'd0);

    // 3: index mismatch; same index field in an R2 is not checked
    fr = {88'd0, 48'h48_000001AA_87};
    do_start(2'b01, 1, 1, 6'd17);
    send_frame(fr, 48, 2, 48, 1);
    check("t3_idxerr", idx_err, 1);
    check_resp("t3a", fr, 48, 1, 1, 6'd17);
    fr = {8'h3F, 80'hA5A5_1234_5678_9ABC_DEF0, 48'h48_000001AA_87};
    do_start(2'b10, 0, 1, 6'd17);
    send_frame(fr, 136, 1, 136, 1);
    check("t3_r2_idx", idx_err, 0);
    check_resp("t3b", fr, 136, 0, 1, 6'd17);

    // 4: end bit low
    fr = {88'd0, 48'h48_000001AA_86};
    do_start(2'b11, 1, 1, 6'd8);
    send_frame(fr, 48, 0, 48, 2);
    check("t4_flags", {to_err, crc_err, end_err, idx_err}, 4'b0010);
    check_resp("t4", fr, 48, 1, 1, 6'd8);

    // 5: 64 idle strobes time out; 63 idle strobes then a frame do not
    do_start(2'b01, 1, 1, 6'd8);
    check("t5_flags_cleared", end_err, 0);
    repeat (64) send_bit(1'b1, 1);
    idle_tick();
    check("t5_to_done", {resp_done, to_err, crc_err, end_err, idx_err}, 5'b11000);
    idle_tick();
    check("t5_to_hold", {resp_done, busy, to_err}, 3'b001);
    fr = {88'd0, 48'h48_000001AA_87};
    do_start(2'b01, 1, 1, 6'd8);
    check("t5_to_cleared", to_err, 0);
    send_frame(fr, 48, 63, 48, 1);
    check_resp("t5b", fr, 48, 1, 1, 6'd8);

    // IDLE start with no response: flags cleared, nothing else happens
    fr = {88'd0, 48'h48_000001AA_86};
    do_start(2'b01, 1, 1, 6'd8);
    send_frame(fr, 48, 0, 48, 0);
    idle_tick();
    d0 = done_seen;
    do_start(2'b00, 1, 1, 6'd8);
    repeat (3) idle_tick();
    check("none_cleared", {busy, end_err, 32'(done_seen - d0)}, 0);

    // 6a: async reset after 20 bits of a frame
    fr = {88'd0, 48'h48_000001AA_87};
    do_start(2'b01, 1, 1, 6'd8);
    send_frame(fr, 48, 0, 21, 1);
    check("t6_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1 check("t6_rst_out", {resp_data, resp_done, busy, to_err, crc_err, end_err, idx_err}, 0);
    @(negedge clk); rst = 1'b0;

    // 6b: restart mid-frame: flags cleared, only the second frame completes
    fr = {88'd0, 48'h48_000001AA_86};
    do_start(2'b01, 1, 1, 6'd8);
    send_frame(fr, 48, 0, 48, 0);
    idle_tick();
    d0 = done_seen;
    fr = {88'd0, 48'h48_000001AA_87};
    do_start(2'b01, 1, 1, 6'd8);
    check("t6_clear_on_start", end_err, 0);
    send_frame(fr, 48, 0, 21, 1);
    do_start(2'b01, 1, 1, 6'd8);
    check("t6_abort_busy", {busy, resp_done}, 2'b10);
    send_frame(fr, 48, 2, 48, 1);
    check_resp("t6b", fr, 48, 1, 1, 6'd8);
    check("t6_one_done", 32'(done_seen - d0), 1);

    // randomized frames
    for (int it = 0; it < 24; it++) begin
      logic       r2, ce, ie;
      logic [5:0] ei;
      logic [1:0] t;
      int         len;
      r2  = 1'($urandom);
      len = r2 ? 136 : 48;
      fr  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (r2) fr[135:128] = 8'h3F;
      else begin fr[135:48] = '0; fr[47] = 1'b0; end
      fr[7:1] = crc7_ref(fr, r2 ? 127 : 47);
      if ($urandom_range(0, 3) == 0) fr[7:1] = fr[7:1] ^ 7'($urandom_range(1, 127));
      fr[0] = ($urandom_range(0, 3) != 0);
      ei = $urandom_range(0, 1) ? fr[45:40] : 6'($urandom);
      ce = 1'($urandom);
      ie = 1'($urandom);
      t  = r2 ? 2'b10 : ($urandom_range(0, 1) ? 2'b01 : 2'b11);
      do_start(t, ce, ie, ei);
      send_frame(fr, len, $urandom_range(0, 20), len, 2);
      check_resp($sformatf("rnd%0d", it), fr, len, ce, ie, ei);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
